// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronises and glitch-filters the raw A/B encoder
// phases, tracks the Gray-coded phase and emits a one-cycle en pulse per valid
// quarter-step with dir giving the direction. Double-phase jumps pulse err.
module quad_step_decoder #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    output logic       en,
    output logic       dir,
    output logic       err,
    output logic [1:0] phase
);

    typedef enum logic {
        INIT,
        TRACK
    } state_t;

    localparam logic [3:0] CNT_LAST  = 4'(FILT_LEN - 1);
    localparam logic [4:0] INIT_LAST = 5'(FILT_LEN + 1);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] icnt;
    logic [4:0] icnt_nxt;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] phase_q;
    logic [3:0] cnt;
    logic       step_up;
    logic       step_dn;
    logic       jump;
    logic [1:0] pos_now;
    logic [1:0] pos_old;
    logic [1:0] delta;

    // Two-flop synchroniser for both raw phases
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {a, b};
            s2 <= s1;
        end
    end

    // State register and INIT-length counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            icnt  <= '0;
        end else begin
            state <= state_nxt;
            icnt  <= icnt_nxt;
        end
    end

    // Next state: INIT lasts FILT_LEN+2 cycles, TRACK holds until reset
    always_comb begin
        state_nxt = state;
        icnt_nxt  = icnt;
        if (state == INIT) begin
            icnt_nxt = icnt + 5'd1;
            if (icnt == INIT_LAST) begin
                state_nxt = TRACK;
            end
        end
    end

    // Phase filter; in INIT both phase and phase_q follow s2 directly so that
    // the first TRACK decode sees no difference for any FILT_LEN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase   <= '0;
            phase_q <= '0;
            cnt     <= '0;
        end else if (state == INIT) begin
            phase   <= s2;
            phase_q <= s2;
            cnt     <= '0;
        end else begin
            phase_q <= phase;
            if (s2 == phase) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                phase <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Gray-to-binary position difference: +1 = down sequence, -1 = up sequence
    always_comb begin
        pos_now = {phase[1], phase[1] ^ phase[0]};
        pos_old = {phase_q[1], phase_q[1] ^ phase_q[0]};
        delta   = pos_now - pos_old;
        step_up = 1'b0;
        step_dn = 1'b0;
        jump    = 1'b0;
        if (state == TRACK) begin
            case (delta)
                2'd3:    step_up = 1'b1;
                2'd1:    step_dn = 1'b1;
                2'd2:    jump    = 1'b1;
                default: ;
            endcase
        end
    end

    // Registered step/error outputs; dir only moves on a valid step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en  <= 1'b0;
            err <= 1'b0;
            dir <= 1'b0;
        end else begin
            en  <= step_up | step_dn;
            err <= jump;
            if (step_up | step_dn) begin
                dir <= step_up;
            end
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed self-checking bench for quad_step_decoder with FILT_LEN = 3.
module tb_quad_step_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a   = 1'b0;
    logic       b   = 1'b0;
    logic       en;
    logic       dir;
    logic       err;
    logic [1:0] phase;

    int checks   = 0;
    int failures = 0;

    quad_step_decoder #(.FILT_LEN(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .en    (en),
        .dir   (dir),
        .err   (err),
        .phase (phase)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic na, input logic nb);
        rst = 1'b0;
        a   = na;
        b   = nb;
        repeat (3) tick();
        rst = 1'b1;
        repeat (10) tick();
    endtask

    // Applies {na,nb}, runs n cycles, records pulse counts and first positions
    task automatic run_window(input logic na, input logic nb, input int n,
                              output int en_cnt, output int en_at,
                              output int err_cnt, output int err_at,
                              output int both, output logic dir_at);
        a = na;
        b = nb;
        en_cnt = 0; en_at = -1; err_cnt = 0; err_at = -1; both = 0; dir_at = 1'bx;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (en === 1'b1) begin
                en_cnt++;
                if (en_at < 0) begin
                    en_at  = i;
                    dir_at = dir;
                end
            end
            if (err === 1'b1) begin
                err_cnt++;
                if (err_at < 0) err_at = i;
            end
            if (en === 1'b1 && err === 1'b1) both++;
        end
    endtask

    task automatic test_reset();
        int bad;
        a = 1'b1;
        b = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({en, err, dir, phase} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_async: {en,err,dir,phase}=%b required 00000", {en, err, dir, phase});
        end
        repeat (3) tick();
        checks++;
        if (phase !== 2'b00) begin
            failures++;
            $display("FAIL reset_phase_held: phase=%b required 00", phase);
        end
        rst = 1'b1;
        bad = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (en !== 1'b0 || err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_init_quiet: pulse cycles=%0d required 0", bad);
        end
        checks++;
        if (phase !== 2'b11) begin
            failures++;
            $display("FAIL reset_init_phase: phase=%b required 11", phase);
        end
        bad = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (en !== 1'b0 || err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_track_quiet: pulse cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_up();
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        int ec, ea, rc, ra, bo;
        logic dv;
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_window(seq[k][1], seq[k][0], 10, ec, ea, rc, ra, bo, dv);
            checks++;
            if (ec != 1 || ea != 6) begin
                failures++;
                $display("FAIL up_pulse[%0d]: count=%0d at=%0d required count=1 at=6", k, ec, ea);
            end
            checks++;
            if (dv !== 1'b1) begin
                failures++;
                $display("FAIL up_dir[%0d]: dir=%b required 1", k, dv);
            end
            checks++;
            if (rc != 0 || bo != 0) begin
                failures++;
                $display("FAIL up_err[%0d]: err=%0d both=%0d required 0 0", k, rc, bo);
            end
            checks++;
            if (phase !== seq[k]) begin
                failures++;
                $display("FAIL up_phase[%0d]: phase=%b required %b", k, phase, seq[k]);
            end
        end
    endtask

    task automatic test_down_then_reverse();
        logic [1:0] seq [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b10};
        logic       xd  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int ec, ea, rc, ra, bo;
        logic dv;
        for (int k = 0; k < 5; k++) begin
            run_window(seq[k][1], seq[k][0], 10, ec, ea, rc, ra, bo, dv);
            checks++;
            if (ec != 1 || ea != 6 || rc != 0) begin
                failures++;
                $display("FAIL down_pulse[%0d]: en=%0d at=%0d err=%0d required en=1 at=6 err=0", k, ec, ea, rc);
            end
            checks++;
            if (dv !== xd[k]) begin
                failures++;
                $display("FAIL down_dir[%0d]: dir=%b required %b", k, dv, xd[k]);
            end
        end
        run_window(1'b1, 1'b0, 20, ec, ea, rc, ra, bo, dv);
        checks++;
        if (ec != 0 || rc != 0 || dir !== 1'b1) begin
            failures++;
            $display("FAIL down_hold: en=%0d err=%0d dir=%b required 0 0 1", ec, rc, dir);
        end
    endtask

    task automatic test_glitch();
        int ec, ea, rc, bo;
        logic dv;
        logic [1:0] ph5, ph8;
        do_reset(1'b0, 1'b0);
        a = 1'b1;
        tick();
        tick();
        a = 1'b0;
        ec = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (en !== 1'b0 || err !== 1'b0 || phase !== 2'b00) ec++;
        end
        checks++;
        if (ec != 0) begin
            failures++;
            $display("FAIL glitch_2cyc: disturbed cycles=%0d required 0", ec);
        end
        a = 1'b1;
        ec = 0; ea = -1; rc = 0; bo = 0; dv = 1'bx; ph5 = 2'bxx; ph8 = 2'bxx;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 3) a = 1'b0;
            if (i == 5) ph5 = phase;
            if (i == 8) ph8 = phase;
            if (en === 1'b1) begin
                ec++;
                if (ea < 0) begin
                    ea = i;
                    dv = dir;
                end
            end
            if (err === 1'b1) rc++;
        end
        checks++;
        if (ea != 6 || dv !== 1'b1) begin
            failures++;
            $display("FAIL glitch_3cyc_step: at=%0d dir=%b required at=6 dir=1", ea, dv);
        end
        checks++;
        if (ph5 !== 2'b10) begin
            failures++;
            $display("FAIL glitch_3cyc_phase: phase=%b required 10", ph5);
        end
        checks++;
        if (ec != 2 || rc != 0 || ph8 !== 2'b00 || dir !== 1'b0) begin
            failures++;
            $display("FAIL glitch_3cyc_return: en=%0d err=%0d phase=%b dir=%b required 2 0 00 0", ec, rc, ph8, dir);
        end
    endtask

    task automatic test_illegal();
        int ec, ea, rc, ra, bo;
        logic dv;
        do_reset(1'b0, 1'b0);
        run_window(1'b1, 1'b1, 10, ec, ea, rc, ra, bo, dv);
        checks++;
        if (rc != 1 || ra != 6 || ec != 0) begin
            failures++;
            $display("FAIL illegal_00_11: err=%0d at=%0d en=%0d required 1 6 0", rc, ra, ec);
        end
        checks++;
        if (dir !== 1'b0 || phase !== 2'b11) begin
            failures++;
            $display("FAIL illegal_00_11_state: dir=%b phase=%b required 0 11", dir, phase);
        end
        run_window(1'b0, 1'b1, 10, ec, ea, rc, ra, bo, dv);
        checks++;
        if (ec != 1 || ea != 6 || dv !== 1'b1 || rc != 0) begin
            failures++;
            $display("FAIL illegal_next_step: en=%0d at=%0d dir=%b err=%0d required 1 6 1 0", ec, ea, dv, rc);
        end
        run_window(1'b1, 1'b0, 10, ec, ea, rc, ra, bo, dv);
        checks++;
        if (rc != 1 || ec != 0 || bo != 0 || dir !== 1'b1 || phase !== 2'b10) begin
            failures++;
            $display("FAIL illegal_01_10: err=%0d en=%0d both=%0d dir=%b phase=%b required 1 0 0 1 10", rc, ec, bo, dir, phase);
        end
    endtask

    task automatic test_reset_midpulse();
        int bad;
        do_reset(1'b0, 1'b0);
        a = 1'b1;
        repeat (6) tick();
        checks++;
        if (en !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pulse: en=%b required 1", en);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (en !== 1'b0 || phase !== 2'b00 || dir !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear: en=%b phase=%b dir=%b required 0 00 0", en, phase, dir);
        end
        tick();
        rst = 1'b1;
        bad = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (en !== 1'b0 || err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || phase !== 2'b10) begin
            failures++;
            $display("FAIL midreset_restart: pulse cycles=%0d phase=%b required 0 10", bad, phase);
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down_then_reverse();
        test_glitch();
        test_illegal();
        test_reset_midpulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete required completion");
        $fatal(1);
    end

endmodule
